pix_hist_calc: RTL

PIX_HIST_CALC -- requirements
Module: pix_hist_calc

---
 rtl/pix_hist_pkg.sv | 21 ++
 rtl/pix_hist_ram.sv | 40 ++++
 rtl/pix_hist_calc.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pix_hist_pkg.sv
// Shared definitions for the pixel histogram block: FSM state encoding,
// pipeline drain depth and the bin-count helper.
package pix_hist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_FLUSH,
        ST_READ
    } hist_state_t;

    // Cycles spent in FLUSH so the read/write increment pipeline is empty.
    localparam int FLUSH_CYCLES = 2;

    // Number of histogram bins for a given pixel width.
    function automatic int unsigned hist_num_bins(input int unsigned pix_w);
        return 32'd1 << pix_w;
    endfunction

endpackage

// File: rtl/pix_hist_ram.sv
// Simple dual-port bin memory: one write port, one read port with a
// registered, enable-gated output. When i_rd_en is low the output keeps
// its last value, which the readout path relies on to hold a stalled word.
module pix_hist_ram
    import pix_hist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int DEPTH = int'(hist_num_bins(ADDR_W));

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rd_data;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port, one cycle latency; returns old data on a same-address write.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pix_hist_calc.sv
// Grayscale pixel histogram: clears the bin memory at start of frame,
// accumulates one pixel per cycle through a read/write increment pipeline
// with forwarding, then streams all bins out under consumer backpressure.
// Optional build macro: PIX_HIST_SAT_EN makes bin counters saturate
// instead of wrapping.
module pix_hist_calc
    import pix_hist_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic             pix_eof,
    output logic             pix_ready,
    output logic [PIX_W-1:0] hist_bin,
    output logic [CNT_W-1:0] hist_cnt,
    output logic             hist_valid,
    output logic             hist_last,
    input  logic             hist_ready,
    output logic             busy
);

    localparam logic [PIX_W-1:0] BIN_MAX    = PIX_W'(hist_num_bins(PIX_W) - 1);
    localparam logic [1:0]       FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    hist_state_t      r_state, w_state_next;
    logic             w_pix_ready, w_accept, w_pipe_rd;
    logic [PIX_W-1:0] r_clr_addr, r_sof_bin, r_rd_ptr;
    logic             r_eof_pend, r_hist_valid;
    logic [1:0]       r_flush_cnt;
    // Increment pipeline: s1 = read returned, wb = value written last cycle.
    logic             r_s1_valid, r_wb_valid;
    logic [PIX_W-1:0] r_s1_bin, r_wb_bin;
    logic [CNT_W-1:0] r_wb_data, w_base, w_incr, w_rd_data, w_wr_data;
    logic             w_rd_en, w_wr_en;
    logic [PIX_W-1:0] w_rd_addr, w_wr_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode and pixel-side handshake.
    always_comb begin
        w_state_next = r_state;
        w_pix_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pix_ready = 1'b1;
                if (pix_valid && pix_sof) w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (r_clr_addr == BIN_MAX) w_state_next = r_eof_pend ? ST_FLUSH : ST_ACCUM;
            end
            ST_ACCUM: begin
                w_pix_ready = 1'b1;
                if (pix_valid && pix_sof)      w_state_next = ST_CLEAR;
                else if (pix_valid && pix_eof) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (r_flush_cnt == FLUSH_LAST) w_state_next = ST_READ;
            end
            ST_READ: begin
                if (r_hist_valid && hist_ready && r_rd_ptr == BIN_MAX) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (rst) w_pix_ready = 1'b0;
    end

    assign w_accept  = pix_valid && w_pix_ready;
    // A restarting sof pixel is not counted here; CLEAR seeds its bin instead.
    assign w_pipe_rd = (r_state == ST_ACCUM) && w_accept && !pix_sof;

    // Frame bookkeeping, clear sweep, flush timer and readout pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_addr   <= '0;
            r_sof_bin    <= '0;
            r_eof_pend   <= 1'b0;
            r_flush_cnt  <= '0;
            r_rd_ptr     <= '0;
            r_hist_valid <= 1'b0;
        end else begin
            if (w_accept && pix_sof) begin
                r_clr_addr <= '0;
                r_sof_bin  <= pix_data;
                r_eof_pend <= pix_eof;
            end else if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + PIX_W'(1);
            end
            r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + 2'd1 : 2'd0;
            if (r_state == ST_FLUSH && w_state_next == ST_READ) begin
                r_hist_valid <= 1'b1;
                r_rd_ptr     <= '0;
            end else if (r_state == ST_READ && r_hist_valid && hist_ready) begin
                if (r_rd_ptr == BIN_MAX) begin
                    r_hist_valid <= 1'b0;
                    r_rd_ptr     <= '0;
                end else begin
                    r_rd_ptr <= r_rd_ptr + PIX_W'(1);
                end
            end
        end
    end

    // Increment pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_wb_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_pipe_rd;
            r_wb_valid <= r_s1_valid;
        end
        r_s1_bin  <= pix_data;
        r_wb_bin  <= r_s1_bin;
        r_wb_data <= w_incr;
    end

    // Forward last cycle's write when the RAM read raced it, then increment.
    always_comb begin
        w_base = (r_wb_valid && r_wb_bin == r_s1_bin) ? r_wb_data : w_rd_data;
`ifdef PIX_HIST_SAT_EN
        w_incr = (w_base == '1) ? w_base : w_base + CNT_W'(1);
`else
        w_incr = w_base + CNT_W'(1);
`endif
    end

    // Bin memory port arbitration between clear, accumulate and readout.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = pix_data;
        w_wr_en   = 1'b0;
        w_wr_addr = r_s1_bin;
        w_wr_data = w_incr;
        if (w_pipe_rd) begin
            w_rd_en = 1'b1;
        end else if (r_state == ST_FLUSH && w_state_next == ST_READ) begin
            w_rd_en   = 1'b1;
            w_rd_addr = '0;
        end else if (r_state == ST_READ && r_hist_valid && hist_ready && r_rd_ptr != BIN_MAX) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_rd_ptr + PIX_W'(1);
        end
        if (r_state == ST_CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_clr_addr;
            w_wr_data = (r_clr_addr == r_sof_bin) ? CNT_W'(1) : '0;
        end else if (r_s1_valid) begin
            w_wr_en = 1'b1;
        end
    end

    pix_hist_ram #(
        .ADDR_W (PIX_W),
        .DATA_W (CNT_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign pix_ready  = w_pix_ready;
    assign hist_valid = r_hist_valid;
    assign hist_bin   = r_rd_ptr;
    assign hist_cnt   = r_hist_valid ? w_rd_data : '0;
    assign hist_last  = r_hist_valid && (r_rd_ptr == BIN_MAX);
    assign busy       = (r_state != ST_IDLE);

endmodule
